// File: rtl/mips_mem_sequencer_pkg.sv
// Shared state encoding, address-select codes and control-strobe bundle for the
// multi-cycle memory sequencer.
package mips_mem_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_FETCH  = 3'd0,
        SEQ_DECODE = 3'd1,
        SEQ_MEM    = 3'd2,
        SEQ_WB     = 3'd3,
        SEQ_TRAP   = 3'd4
    } seq_state_t;

    localparam logic ADDR_PC   = 1'b0;
    localparam logic ADDR_DATA = 1'b1;

    typedef struct packed {
        logic mem_req;
        logic mem_addr_sel;
        logic mem_word_we;
        logic mem_byte_we;
        logic ir_we;
        logic mdr_we;
        logic rf_we;
        logic pc_we;
        logic trap;
    } seq_ctrl_t;

    function automatic logic is_mem_op(input logic rd, input logic wwe, input logic bwe);
        return rd | wwe | bwe;
    endfunction

endpackage

// File: rtl/mips_mem_sequencer_mem_wait_timer.sv
// Counts un-acked memory request cycles; expired flags the last cycle allowed
// before the sequencer gives up on the request.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable)
            r_count <= r_count + 1'b1;
    end

    assign o_expired = (r_count == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mips_mem_sequencer.sv
// Multi-cycle FETCH/DECODE/MEM/WB sequencer sharing one memory port.
// Optional request timeout with sticky bus_error: define MEM_TIMEOUT_EN.
module mips_mem_sequencer
    import mips_mem_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_mem_read,
    input  logic       i_word_we,
    input  logic       i_byte_we,
    input  logic       i_writeenable,
    input  logic       i_except,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_addr_sel,
    output logic       o_mem_word_we,
    output logic       o_mem_byte_we,
    output logic       o_ir_we,
    output logic       o_mdr_we,
    output logic       o_rf_we,
    output logic       o_pc_we,
    output logic       o_trap,
    output logic       o_bus_error,
    output logic [2:0] o_state
);

    if ((2 ** WAIT_W) <= (MAX_WAIT - 1)) begin : g_wait_w_too_small
        $error("WAIT_W too narrow for MAX_WAIT");
    end

    seq_state_t r_state;
    seq_state_t w_next;
    seq_ctrl_t  w_ctrl;
    logic       w_mem_op;
    logic       w_timeout;

    assign w_mem_op = is_mem_op(i_mem_read, i_word_we, i_byte_we);

`ifdef MEM_TIMEOUT_EN
    logic w_expired;
    logic w_timer_clr;
    logic r_bus_error;

    // Clear on every entry into a requesting state so each request gets a fresh budget.
    assign w_timer_clr = (w_next != r_state) && ((w_next == SEQ_FETCH) || (w_next == SEQ_MEM));

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (w_timer_clr),
        .i_enable  (w_ctrl.mem_req & ~i_mem_ready),
        .o_expired (w_expired)
    );

    assign w_timeout = w_expired & w_ctrl.mem_req & ~i_mem_ready;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_bus_error <= 1'b0;
        else if (w_timeout)
            r_bus_error <= 1'b1;
    end

    assign o_bus_error = r_bus_error;
`else
    assign w_timeout   = 1'b0;
    assign o_bus_error = 1'b0;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_state <= SEQ_FETCH;
        else
            r_state <= w_next;
    end

    // An ack always beats a coincident timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            SEQ_FETCH: begin
                if (i_mem_ready)
                    w_next = SEQ_DECODE;
                else if (w_timeout)
                    w_next = SEQ_TRAP;
            end
            SEQ_DECODE: begin
                if (i_except)
                    w_next = SEQ_TRAP;
                else if (w_mem_op)
                    w_next = SEQ_MEM;
                else
                    w_next = SEQ_FETCH;
            end
            SEQ_MEM: begin
                if (i_mem_ready)
                    w_next = i_mem_read ? SEQ_WB : SEQ_FETCH;
                else if (w_timeout)
                    w_next = SEQ_TRAP;
            end
            SEQ_WB:   w_next = SEQ_FETCH;
            SEQ_TRAP: w_next = SEQ_TRAP;
            default:  w_next = SEQ_FETCH;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            SEQ_FETCH: begin
                w_ctrl.mem_req      = 1'b1;
                w_ctrl.mem_addr_sel = ADDR_PC;
                w_ctrl.ir_we        = i_mem_ready;
            end
            SEQ_DECODE: begin
                if (!i_except && !w_mem_op) begin
                    w_ctrl.rf_we = i_writeenable;
                    w_ctrl.pc_we = 1'b1;
                end
            end
            SEQ_MEM: begin
                w_ctrl.mem_req      = 1'b1;
                w_ctrl.mem_addr_sel = ADDR_DATA;
                w_ctrl.mem_word_we  = i_word_we;
                w_ctrl.mem_byte_we  = i_byte_we;
                w_ctrl.mdr_we       = i_mem_ready & i_mem_read;
                w_ctrl.pc_we        = i_mem_ready & ~i_mem_read;
            end
            SEQ_WB: begin
                w_ctrl.rf_we = 1'b1;
                w_ctrl.pc_we = 1'b1;
            end
            SEQ_TRAP: w_ctrl.trap = 1'b1;
            default:  w_ctrl = '0;
        endcase
    end

    // Strobes are forced low for the whole reset pulse, not just after the edge.
    assign o_mem_req      = w_ctrl.mem_req      & ~i_reset;
    assign o_mem_addr_sel = w_ctrl.mem_addr_sel & ~i_reset;
    assign o_mem_word_we  = w_ctrl.mem_word_we  & ~i_reset;
    assign o_mem_byte_we  = w_ctrl.mem_byte_we  & ~i_reset;
    assign o_ir_we        = w_ctrl.ir_we        & ~i_reset;
    assign o_mdr_we       = w_ctrl.mdr_we       & ~i_reset;
    assign o_rf_we        = w_ctrl.rf_we        & ~i_reset;
    assign o_pc_we        = w_ctrl.pc_we        & ~i_reset;
    assign o_trap         = w_ctrl.trap         & ~i_reset;
    assign o_state        = i_reset ? 3'd0 : r_state;

endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Self-checking bench: builds per-instruction expected output traces from the
// sequencing rules, replays them cycle by cycle and compares every cycle.
module tb_mips_mem_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, rdy = 1'b0, mr = 1'b0, ww = 1'b0, bw = 1'b0, we = 1'b0, ex = 1'b0;
    logic o_mem_req, o_mem_addr_sel, o_mem_word_we, o_mem_byte_we, o_ir_we, o_mdr_we;
    logic o_rf_we, o_pc_we, o_trap, o_bus_error;
    logic [2:0] o_state;

    mips_mem_sequencer dut (
        .i_clock(clk), .i_reset(rst), .i_mem_read(mr), .i_word_we(ww), .i_byte_we(bw),
        .i_writeenable(we), .i_except(ex), .i_mem_ready(rdy),
        .o_mem_req(o_mem_req), .o_mem_addr_sel(o_mem_addr_sel), .o_mem_word_we(o_mem_word_we),
        .o_mem_byte_we(o_mem_byte_we), .o_ir_we(o_ir_we), .o_mdr_we(o_mdr_we), .o_rf_we(o_rf_we),
        .o_pc_we(o_pc_we), .o_trap(o_trap), .o_bus_error(o_bus_error), .o_state(o_state)
    );

    typedef struct packed {
        logic req, sel, wwe, bwe, ir, mdr, rf, pc, trap, be;
        logic [2:0] st;
    } outs_t;

    typedef struct {
        logic  rst, rdy, mr, ww, bw, we, ex;
        outs_t exp;
        string tag;
    } ent_t;

    ent_t  q[$];
    int    checks = 0, errors = 0, cyc = 0;
    outs_t cur_exp;
    string cur_tag;
    bit    exp_vld = 0;
    logic  exp_be = 1'b0;

    // Single compare process, mid-cycle.
    always @(negedge clk) begin
        outs_t act;
        if (exp_vld) begin
            act = {o_mem_req, o_mem_addr_sel, o_mem_word_we, o_mem_byte_we, o_ir_we, o_mdr_we,
                   o_rf_we, o_pc_we, o_trap, o_bus_error, o_state};
            checks++;
            if (act !== cur_exp) begin
                errors++;
                $display("FAIL cyc%0d %s: got %b required %b (req sel wwe bwe ir mdr rf pc trap be st)",
                         cyc, cur_tag, act, cur_exp);
            end
        end
    end

    function automatic outs_t base(input logic [2:0] st);
        outs_t o = '0;
        o.st = st;
        o.be = exp_be;
        return o;
    endfunction

    function automatic void push(input logic r, input logic rd, input logic [4:0] d,
                                 input outs_t o, input string tag);
        ent_t e;
        e.rst = r; e.rdy = rd;
        e.mr = d[0]; e.ww = d[1]; e.bw = d[2]; e.we = d[3]; e.ex = d[4];
        e.exp = o; e.tag = tag;
        q.push_back(e);
    endfunction

    task automatic push_reset(input string tag);
        exp_be = 1'b0;
        push(1'b1, 1'(($urandom)), 5'($urandom), '0, tag);
    endtask

    // Expected trace for one instruction: fw fetch waits, mw data waits.
    task automatic build(input logic imr, iww, ibw, iwe, iex, input int fw, mw, input string tag);
        outs_t o;
        logic [4:0] d;
        logic memop;
        d = {iex, iwe, ibw, iww, imr};
        memop = imr | iww | ibw;
        for (int i = 0; i < fw; i++) begin
            o = base(3'd0); o.req = 1'b1;
            push(1'b0, 1'b0, 5'($urandom), o, {tag, "/fetch_wait"});
        end
        o = base(3'd0); o.req = 1'b1; o.ir = 1'b1;
        push(1'b0, 1'b1, 5'($urandom), o, {tag, "/fetch_ack"});
        o = base(3'd1);
        if (!iex && !memop) begin o.rf = iwe; o.pc = 1'b1; end
        push(1'b0, 1'(($urandom)), d, o, {tag, "/decode"});
        if (iex) begin
            for (int i = 0; i < 20; i++) begin
                o = base(3'd4); o.trap = 1'b1;
                push(1'b0, 1'(($urandom)), d, o, {tag, "/trap"});
            end
        end else if (memop) begin
            for (int i = 0; i < mw; i++) begin
                o = base(3'd2); o.req = 1'b1; o.sel = 1'b1; o.wwe = iww; o.bwe = ibw;
                push(1'b0, 1'b0, d, o, {tag, "/mem_wait"});
            end
            o = base(3'd2); o.req = 1'b1; o.sel = 1'b1; o.wwe = iww; o.bwe = ibw;
            o.mdr = imr; o.pc = ~imr;
            push(1'b0, 1'b1, d, o, {tag, "/mem_ack"});
            if (imr) begin
                o = base(3'd3); o.rf = 1'b1; o.pc = 1'b1;
                push(1'b0, 1'(($urandom)), d, o, {tag, "/wb"});
            end
        end
    endtask

    task automatic pin(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL pin %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic play();
        foreach (q[i]) begin
            @(posedge clk); #1;
            rst = q[i].rst; rdy = q[i].rdy;
            mr = q[i].mr; ww = q[i].ww; bw = q[i].bw; we = q[i].we; ex = q[i].ex;
            cur_exp = q[i].exp; cur_tag = q[i].tag; exp_vld = 1'b1; cyc++;
        end
        q.delete();
    endtask

    initial begin
        int b, n;
        outs_t o;

        push_reset("reset_state");
        push_reset("reset_hold");

        // add, zero-wait: FETCH, DECODE, then FETCH again
        b = q.size();
        build(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "add");
        pin("add_len", q.size() - b, 2);
        pin("add_ir_c0", int'(q[b].exp.ir), 1);
        pin("add_rfpc_c1", int'(q[b+1].exp.rf & q[b+1].exp.pc), 1);

        // lw with two data wait cycles
        b = q.size();
        build(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 2, "lw");
        n = 0;
        for (int i = b; i < q.size(); i++) n += int'(q[i].exp.sel);
        pin("lw_sel_cycles", n, 3);
        pin("lw_mdr_c4", int'(q[b+4].exp.mdr), 1);
        pin("lw_rfpc_c5", int'(q[b+5].exp.rf & q[b+5].exp.pc), 1);

        // sb, zero-wait
        b = q.size();
        build(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "sb");
        pin("sb_len", q.size() - b, 3);
        pin("sb_bwe_c2", int'(q[b+2].exp.bwe & q[b+2].exp.pc), 1);
        pin("sb_bwe_c1", int'(q[b+1].exp.bwe), 0);
        play();

        // randomized instruction mix with random memory latency
        for (int k = 0; k < 40; k++) begin
            int kind, fw, mw;
            kind = $urandom_range(0, 6);
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            case (kind)
                0, 6: build(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fw, mw, "rnd_alu");
                1:    build(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fw, mw, "rnd_branch");
                2:    build(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fw, mw, "rnd_lw");
                3:    build(1'b1, 1'b0, 1'b0, 1'(($urandom)), 1'b0, fw, mw, "rnd_addm");
                4:    build(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, fw, mw, "rnd_sw");
                default: build(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fw, mw, "rnd_sb");
            endcase
        end
        play();

        // reset in the middle of a word store's data wait
        build(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 5, "sw_abort");
        while (q.size() > 5) void'(q.pop_back());
        pin("sw_abort_in_mem", int'(q[4].exp.wwe), 1);
        push_reset("reset_mid_mem");
        o = base(3'd0); o.req = 1'b1;
        push(1'b0, 1'b0, 5'($urandom), o, "after_reset_fetch");
        build(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "add_after_reset");

        // illegal instruction: trap with random ready pulses, left only by reset
        build(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0, "except");
        push_reset("reset_from_trap");
        build(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1, "lbu_after_trap");
        play();

`ifdef MEM_TIMEOUT_EN
        // fetch never acked: 15 request cycles then TRAP with sticky bus_error
        for (int i = 0; i < 15; i++) begin
            o = base(3'd0); o.req = 1'b1;
            push(1'b0, 1'b0, 5'($urandom), o, "timeout_wait");
        end
        exp_be = 1'b1;
        for (int i = 0; i < 4; i++) begin
            o = base(3'd4); o.trap = 1'b1;
            push(1'b0, 1'(($urandom)), 5'($urandom), o, "timeout_trap");
        end
        push_reset("reset_after_timeout");
        // ack on the 15th request cycle wins over the timeout
        build(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14, 0, "ack_on_last");
        build(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 14, "lw_ack_on_last");
        play();
`endif

        @(posedge clk); #1;
        exp_vld = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
